// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial transmit scheduler.
//   state_t      : scheduler state encoding
//   idx_width()  : bits needed to index n items (minimum 1)
//   burst_count(): serializer bytes per word
//   widths_ok()  : word width must be a non-zero multiple of byte width
package p2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned burst_count(input int unsigned p_width,
                                              input int unsigned s_width);
    return (s_width == 0) ? 0 : p_width / s_width;
  endfunction

  function automatic bit widths_ok(input int unsigned p_width,
                                   input int unsigned s_width);
    return (s_width != 0) && (p_width >= s_width) && ((p_width % s_width) == 0);
  endfunction

endpackage

// File: rtl/p2s_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   last    : index of the most recently served requester
//   gnt     : one-hot grant (zero when req is zero)
//   gnt_idx : index of the granted requester
// Search order is last+1, last+2, ... modulo NREQ.
module p2s_tx_scheduler_rr_arbiter
  import p2s_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  int unsigned cand;
  logic        found;

  // First set bit after the last winner wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = (32'(last) + i) % NREQ;
      if (!found && req[IW'(cand)]) begin
        found          = 1'b1;
        gnt[IW'(cand)] = 1'b1;
        gnt_idx        = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/p2s_tx_scheduler.sv
// Round-robin scheduler sharing one 24->8 serializer between NREQ word
// sources and draining the captured bytes to a UART transmitter.
//   clk, rst            : clock, synchronous active-high reset
//   req, req_data, ack  : requester levels, packed words, accept pulses
//   p2s_load, p2s_data  : serializer load strobe and parallel word
//   p2s_out/valid/busy  : serializer byte stream and status
//   tx_data/valid/ready : byte handshake towards the UART
//   grant_id, idle      : current/last winner, scheduler idle flag
module p2s_tx_scheduler
  import p2s_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned P_WIDTH = 24,
  parameter int unsigned S_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req,
  input  logic [NREQ*P_WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]             ack,
  output logic                        p2s_load,
  output logic [P_WIDTH-1:0]          p2s_data,
  input  logic [S_WIDTH-1:0]          p2s_out,
  input  logic                        p2s_valid,
  input  logic                        p2s_busy,
  output logic [S_WIDTH-1:0]          tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [idx_width(NREQ)-1:0]  grant_id,
  output logic                        idle
);

  localparam int unsigned COUNT = burst_count(P_WIDTH, S_WIDTH);
  localparam int unsigned IW    = idx_width(NREQ);
  localparam int unsigned CW    = idx_width(COUNT);

  if (!widths_ok(P_WIDTH, S_WIDTH)) begin : g_bad_width
    $error("p2s_tx_scheduler: P_WIDTH must be a non-zero multiple of S_WIDTH");
  end
  if ((NREQ < 2) || (NREQ > 8)) begin : g_bad_nreq
    $error("p2s_tx_scheduler: NREQ must be in 2..8");
  end

  state_t              state, state_nxt;
  logic [IW-1:0]       last, last_nxt;
  logic [IW-1:0]       grant_id_nxt;
  logic [NREQ-1:0]     grant_oh, grant_oh_nxt;
  logic [P_WIDTH-1:0]  p2s_data_nxt;
  logic                p2s_load_nxt;
  logic [NREQ-1:0]     ack_nxt;
  logic [CW-1:0]       wcnt, wcnt_nxt;
  logic [CW-1:0]       rcnt, rcnt_nxt;
  logic [S_WIDTH-1:0]  byte_buf     [COUNT];
  logic [S_WIDTH-1:0]  byte_buf_nxt [COUNT];
  logic                tx_valid_nxt;
  logic [S_WIDTH-1:0]  tx_data_nxt;
  logic                idle_nxt;
  logic [NREQ-1:0]     arb_gnt;
  logic [IW-1:0]       arb_idx;

  p2s_tx_scheduler_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req     (req),
    .last    (last),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt    = state;
    last_nxt     = last;
    grant_id_nxt = grant_id;
    grant_oh_nxt = grant_oh;
    p2s_data_nxt = p2s_data;
    p2s_load_nxt = 1'b0;
    ack_nxt      = '0;
    wcnt_nxt     = wcnt;
    rcnt_nxt     = rcnt;
    byte_buf_nxt = byte_buf;
    tx_valid_nxt = tx_valid;
    tx_data_nxt  = tx_data;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          grant_id_nxt = arb_idx;
          grant_oh_nxt = arb_gnt;
          p2s_data_nxt = req_data[32'(arb_idx)*P_WIDTH +: P_WIDTH];
          state_nxt    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!p2s_busy) begin
          p2s_load_nxt = 1'b1;
          ack_nxt      = grant_oh;
          state_nxt    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (p2s_valid) begin
          byte_buf_nxt[wcnt] = p2s_out;
          if (wcnt == CW'(COUNT-1)) begin
            // First byte presented to the UART straight from the new buffer.
            wcnt_nxt     = '0;
            tx_valid_nxt = 1'b1;
            tx_data_nxt  = byte_buf_nxt[0];
            state_nxt    = ST_DRAIN;
          end else begin
            wcnt_nxt = wcnt + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (tx_ready) begin
          if (rcnt == CW'(COUNT-1)) begin
            tx_valid_nxt = 1'b0;
            last_nxt     = grant_id;
            rcnt_nxt     = '0;
            state_nxt    = ST_IDLE;
          end else begin
            rcnt_nxt    = rcnt + CW'(1);
            tx_data_nxt = byte_buf[rcnt + CW'(1)];
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    idle_nxt = (state_nxt == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last     <= IW'(NREQ-1);
      grant_id <= '0;
      grant_oh <= '0;
      p2s_data <= '0;
      p2s_load <= 1'b0;
      ack      <= '0;
      wcnt     <= '0;
      rcnt     <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      idle     <= 1'b1;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      grant_id <= grant_id_nxt;
      grant_oh <= grant_oh_nxt;
      p2s_data <= p2s_data_nxt;
      p2s_load <= p2s_load_nxt;
      ack      <= ack_nxt;
      wcnt     <= wcnt_nxt;
      rcnt     <= rcnt_nxt;
      tx_valid <= tx_valid_nxt;
      tx_data  <= tx_data_nxt;
      idle     <= idle_nxt;
    end
  end

  // Byte buffer carries no reset; it is always written before it is read.
  always_ff @(posedge clk) begin
    byte_buf <= byte_buf_nxt;
  end

endmodule

// File: tb/tb_p2s_tx_scheduler.sv
// Self-checking bench for p2s_tx_scheduler with a behavioural serializer
// and a word/byte scoreboard driven by the round-robin rule.
module tb_p2s_tx_scheduler;
  import p2s_pkg::*;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned PW    = 24;
  localparam int unsigned SW    = 8;
  localparam int unsigned COUNT = PW / SW;
  localparam int unsigned IW    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*PW-1:0] req_data;
  logic [NREQ-1:0]   ack;
  logic              p2s_load;
  logic [PW-1:0]     p2s_data;
  logic [SW-1:0]     p2s_out;
  logic              p2s_valid;
  logic              p2s_busy;
  logic [SW-1:0]     tx_data;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [IW-1:0]     grant_id;
  logic              idle;

  logic [PW-1:0]     word [NREQ];
  logic              ser_busy  = 1'b0;
  logic              ser_valid = 1'b0;
  logic [SW-1:0]     ser_out   = '0;
  logic              busy_hold = 1'b0;
  bit                ser_gap_en = 1'b0;
  logic [SW-1:0]     ser_q [$];

  int                tests_run    = 0;
  int                tests_failed = 0;
  logic [SW-1:0]     exp_bytes [$];
  int                grants_q [$];
  int                model_last = NREQ - 1;
  bit                auto_drop  = 1'b1;
  int                ack_cnt = 0, load_cnt = 0, tx_cnt = 0, cyc = 0;
  bit                prev_stall = 1'b0;
  logic [SW-1:0]     prev_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NREQ; g++) begin : g_rd
    assign req_data[g*PW +: PW] = word[g];
  end
  assign p2s_busy  = ser_busy | busy_hold;
  assign p2s_valid = ser_valid;
  assign p2s_out   = ser_out;

  p2s_tx_scheduler #(.NREQ(NREQ), .P_WIDTH(PW), .S_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack),
    .p2s_load(p2s_load), .p2s_data(p2s_data), .p2s_out(p2s_out),
    .p2s_valid(p2s_valid), .p2s_busy(p2s_busy), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .grant_id(grant_id), .idle(idle)
  );

  // Behavioural serializer: after a load, emits the word MSB byte first,
  // optionally with idle gaps, and reports busy until the burst is done.
  always begin
    @(negedge clk);
    if (ser_q.size() != 0) begin
      if (ser_gap_en && ($urandom_range(3) == 0)) begin
        ser_valid = 1'b0;
      end else begin
        ser_valid = 1'b1;
        ser_out   = ser_q.pop_front();
      end
    end else begin
      ser_valid = 1'b0;
      ser_busy  = 1'b0;
    end
    if (p2s_load) begin
      for (int b = 0; b < COUNT; b++) ser_q.push_back(p2s_data[PW-1-b*SW -: SW]);
      ser_busy = 1'b1;
    end
  end

  // Scoreboard: grants follow the round-robin rule, bytes leave in order.
  always begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          tests_failed++;
          $display("FAIL stall_hold: tx_valid=%0b tx_data=%h, required 1 and %h", tx_valid, tx_data, prev_data);
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (p2s_load) load_cnt++;
      if (ack != '0) begin
        int pick;
        pick = -1;
        for (int k = 1; k <= NREQ; k++) begin
          int j;
          j = (model_last + k) % NREQ;
          if (pick < 0 && req[j]) pick = j;
        end
        ack_cnt++;
        tests_run++;
        if (pick < 0) begin
          tests_failed++;
          $display("FAIL grant: ack=%b with no pending request", ack);
        end else if (ack !== (NREQ'(1) << pick) || p2s_load !== 1'b1 || grant_id !== IW'(pick) ||
                     p2s_data !== word[pick] || exp_bytes.size() != 0) begin
          tests_failed++;
          $display("FAIL grant: ack=%b load=%0b grant_id=%0d data=%h pending=%0d, required ack for %0d load=1 data=%h pending=0",
                   ack, p2s_load, grant_id, p2s_data, exp_bytes.size(), pick, word[pick]);
        end
        if (pick >= 0) begin
          grants_q.push_back(pick);
          for (int b = 0; b < COUNT; b++) exp_bytes.push_back(word[pick][PW-1-b*SW -: SW]);
          model_last = pick;
          if (auto_drop) req[pick] = 1'b0;
        end
      end else if (p2s_load) begin
        tests_run++;
        tests_failed++;
        $display("FAIL load_ack: p2s_load=1 with ack=%b, required a coincident ack", ack);
      end
      if (tx_valid && tx_ready) begin
        logic [SW-1:0] e;
        tests_run++;
        tx_cnt++;
        if (exp_bytes.size() == 0) begin
          tests_failed++;
          $display("FAIL tx_byte: unexpected byte %h, required none", tx_data);
        end else begin
          e = exp_bytes.pop_front();
          if (tx_data !== e) begin
            tests_failed++;
            $display("FAIL tx_byte: got %h, required %h", tx_data, e);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; req = '0; tx_ready = 1'b0; busy_hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_bytes.delete();
    model_last = NREQ - 1;
    rst = 1'b0;
  endtask

  // Waits until all requests are served and the scheduler is idle again.
  task automatic wait_done(input bit rand_ready, input string name);
    int n;
    n = 0;
    tests_run++;
    while (!(req == '0 && idle === 1'b1 && exp_bytes.size() == 0) && n < 2000) begin
      tx_ready = rand_ready ? 1'($urandom_range(1)) : 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      tests_failed++;
      $display("FAIL %s_timeout: req=%b idle=%0b pending=%0d, required all served", name, req, idle, exp_bytes.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run += 7;
    if (ack !== '0)      begin tests_failed++; $display("FAIL rst_ack: %b, required 0", ack); end
    if (p2s_load !== 0)  begin tests_failed++; $display("FAIL rst_load: %b, required 0", p2s_load); end
    if (p2s_data !== '0) begin tests_failed++; $display("FAIL rst_p2s_data: %h, required 0", p2s_data); end
    if (tx_valid !== 0)  begin tests_failed++; $display("FAIL rst_tx_valid: %b, required 0", tx_valid); end
    if (tx_data !== '0)  begin tests_failed++; $display("FAIL rst_tx_data: %h, required 0", tx_data); end
    if (grant_id !== '0) begin tests_failed++; $display("FAIL rst_grant_id: %0d, required 0", grant_id); end
    if (idle !== 1'b1)   begin tests_failed++; $display("FAIL rst_idle: %b, required 1", idle); end
    do_reset();
  endtask

  task automatic test_single_word();
    int a0, l0, t0, lc, fv, n;
    word[0] = 24'hA1B2C3;
    a0 = ack_cnt; l0 = load_cnt; t0 = tx_cnt; lc = -1; fv = -1; n = 0;
    tx_ready = 1'b1;
    req = 4'b0001;
    while (!(fv >= 0 && req == '0 && idle === 1'b1 && exp_bytes.size() == 0) && n < 100) begin
      @(posedge clk); #1;
      if (p2s_load === 1'b1 && lc < 0) lc = cyc;
      if (tx_valid === 1'b1 && fv < 0) fv = cyc;
      n++;
    end
    tests_run += 4;
    if (ack_cnt - a0 != 1 || load_cnt - l0 != 1) begin
      tests_failed++; $display("FAIL single_pulses: acks=%0d loads=%0d, required 1 and 1", ack_cnt - a0, load_cnt - l0);
    end
    if (tx_cnt - t0 != 3) begin tests_failed++; $display("FAIL single_bytes: %0d, required 3", tx_cnt - t0); end
    if (lc < 0 || fv < 0 || fv - lc < 1 || fv - lc > COUNT + 3) begin
      tests_failed++; $display("FAIL single_latency: load@%0d valid@%0d, required within %0d", lc, fv, COUNT + 3);
    end
    if (idle !== 1'b1) begin tests_failed++; $display("FAIL single_idle: %b, required 1", idle); end
  endtask

  task automatic test_contention();
    int a0, t0;
    do_reset();
    for (int i = 0; i < NREQ; i++) word[i] = PW'($urandom);
    grants_q.delete();
    a0 = ack_cnt; t0 = tx_cnt;
    req = 4'b1011;
    wait_done(1'b1, "contention");
    tests_run += 2;
    if (grants_q.size() != 3 || grants_q[0] != 0 || grants_q[1] != 1 || grants_q[2] != 3) begin
      tests_failed++; $display("FAIL contention_order: %p, required 0 1 3", grants_q);
    end
    if (ack_cnt - a0 != 3 || tx_cnt - t0 != 9) begin
      tests_failed++; $display("FAIL contention_counts: acks=%0d bytes=%0d, required 3 and 9", ack_cnt - a0, tx_cnt - t0);
    end
  endtask

  task automatic test_backpressure();
    int pat [6] = '{0, 0, 1, 0, 1, 1};
    logic [SW-1:0] bp [3] = '{8'hA1, 8'hB2, 8'hC3};
    int acc, t0, n;
    word[0] = 24'hA1B2C3;
    tx_ready = 1'b0; t0 = tx_cnt; acc = 0; n = 0;
    req = 4'b0001;
    while (tx_valid !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 6; i++) begin
      tx_ready = 1'(pat[i]);
      @(negedge clk);
      tests_run++;
      if (tx_valid !== 1'b1 || tx_data !== bp[acc]) begin
        tests_failed++; $display("FAIL bp_data[%0d]: valid=%b data=%h, required 1 and %h", i, tx_valid, tx_data, bp[acc]);
      end
      if (pat[i] != 0) acc++;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tests_run += 2;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_end_valid: %b, required 0", tx_valid); end
    if (tx_cnt - t0 != 3) begin tests_failed++; $display("FAIL bp_transfers: %0d, required 3", tx_cnt - t0); end
    wait_done(1'b0, "backpressure");
  endtask

  task automatic test_busy();
    int n;
    word[1] = PW'($urandom);
    busy_hold = 1'b1; tx_ready = 1'b1; n = 0;
    req = 4'b0010;
    while (idle !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (p2s_load !== 1'b0 || ack !== '0) begin
        tests_failed++; $display("FAIL busy_hold[%0d]: load=%b ack=%b, required 0 and 0", i, p2s_load, ack);
      end
    end
    busy_hold = 1'b0;
    @(negedge clk);
    tests_run++;
    if (p2s_load !== 1'b1 || ack !== 4'b0010) begin
      tests_failed++; $display("FAIL busy_release: load=%b ack=%b, required 1 and 0010", p2s_load, ack);
    end
    wait_done(1'b0, "busy");
  endtask

  task automatic test_reset_mid_drain();
    int base, n, t0;
    word[0] = 24'hA1B2C3;
    tx_ready = 1'b1; base = tx_cnt; n = 0;
    req = 4'b0001;
    while (tx_cnt < base + 2 && n < 100) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run += 3;
    if (tx_valid !== 1'b0) begin tests_failed++; $display("FAIL rmd_tx_valid: %b, required 0", tx_valid); end
    if (idle !== 1'b1)     begin tests_failed++; $display("FAIL rmd_idle: %b, required 1", idle); end
    if (grant_id !== '0)   begin tests_failed++; $display("FAIL rmd_grant_id: %0d, required 0", grant_id); end
    exp_bytes.delete();
    model_last = NREQ - 1;
    @(posedge clk); #1;
    rst = 1'b0;
    word[2] = PW'($urandom);
    grants_q.delete();
    t0 = tx_cnt;
    req = 4'b0100;
    wait_done(1'b0, "rmd");
    tests_run++;
    if (grants_q.size() != 1 || grants_q[0] != 2 || tx_cnt - t0 != 3) begin
      tests_failed++; $display("FAIL rmd_next: grants=%p bytes=%0d, required 2 and 3", grants_q, tx_cnt - t0);
    end
  endtask

  task automatic test_rr_wrap();
    int n;
    int exp_g [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) word[i] = PW'($urandom);
    grants_q.delete();
    auto_drop = 1'b0; tx_ready = 1'b1; n = 0;
    req = 4'b1111;
    while (grants_q.size() < 5 && n < 500) begin @(posedge clk); #1; n++; end
    req = '0;
    auto_drop = 1'b1;
    wait_done(1'b0, "rr_wrap");
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= grants_q.size() || grants_q[i] != exp_g[i]) begin
        tests_failed++;
        $display("FAIL rr_wrap[%0d]: got %0d, required %0d", i, (i < grants_q.size()) ? grants_q[i] : -1, exp_g[i]);
      end
    end
  endtask

  task automatic test_random();
    int a0;
    logic [NREQ-1:0] mask;
    ser_gap_en = 1'b1;
    for (int r = 0; r < 25; r++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) word[i] = PW'($urandom);
      a0 = ack_cnt;
      req = mask;
      wait_done(1'b1, "random");
      tests_run++;
      if (ack_cnt - a0 != $countones(mask)) begin
        tests_failed++; $display("FAIL random_acks[%0d]: %0d, required %0d", r, ack_cnt - a0, $countones(mask));
      end
    end
    ser_gap_en = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) word[i] = '0;
    test_reset();
    test_single_word();
    test_contention();
    test_backpressure();
    test_busy();
    test_reset_mid_drain();
    test_rr_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/p2s_tx_scheduler.md
Name: p2s_tx_scheduler

Overview:
- Round-robin scheduler that shares one parallel_to_serial instance (24->8 bit) between NREQ word sources and feeds the resulting bytes to the UART transmitter.
- Sequence per word: grant a requester, drive the serializer load, capture the serializer's burst of COUNT bytes into a local buffer, then drain the buffer to the UART through a valid/ready handshake.
- Sits between packet producers and uart_tx; it is the only block that drives the serializer's load.

Parameters:
- NREQ, 4: number of requesters (2..8).
- P_WIDTH, 24: word width; must equal the serializer's P_WIDTH.
- S_WIDTH, 8: byte width; must equal the serializer's S_WIDTH. P_WIDTH must be a multiple of S_WIDTH; elaboration fails otherwise.
- Derived: COUNT = P_WIDTH/S_WIDTH (3 by default).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until acked.
- req_data  in  NREQ*P_WIDTH  word for requester i in bits [i*P_WIDTH +: P_WIDTH].
- ack  out  NREQ  one-cycle pulse; word of requester i accepted.
- p2s_load  out  1  serializer load strobe.
- p2s_data  out  P_WIDTH  serializer parallel_in.
- p2s_out  in  S_WIDTH  serializer serial_out.
- p2s_valid  in  1  serializer valid.
- p2s_busy  in  1  serializer busy.
- tx_data  out  S_WIDTH  byte to UART.
- tx_valid  out  1  byte present.
- tx_ready  in  1  UART accepts the byte.
- grant_id  out  clog2(NREQ)  current or last granted requester.
- idle  out  1  high in IDLE.

Behaviour:
- All outputs are driven from registers or the state register; none is combinational from inputs.
- Reset values:
  - ack=0, p2s_load=0, p2s_data=0, tx_valid=0, tx_data=0, grant_id=0, idle=1.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
  - Byte counters=0; buffer contents are don't-care.
- Reset mid-operation aborts the word. The requester is not re-acked; any serializer burst already in flight is ignored.
- States IDLE, LOAD, CAPTURE, DRAIN:
  - IDLE: if req!=0, pick the first set bit searching last+1, last+2, ... (mod NREQ). Register grant_id and p2s_data <= word, then go to LOAD. If req==0, stay in IDLE.
  - LOAD: if p2s_busy==0, assert p2s_load and ack[grant_id] for exactly this one cycle, then go to CAPTURE. If p2s_busy==1, stay in LOAD with p2s_load=0 and ack=0.
  - CAPTURE: on each cycle with p2s_valid=1, buf[wcnt] <= p2s_out and wcnt++. When the COUNT-th byte is written, go to DRAIN with wcnt cleared. Cycles with p2s_valid=0 are ignored.
  - DRAIN:
    - tx_valid=1, tx_data=buf[rcnt].
    - On tx_valid&&tx_ready, rcnt++ and tx_data advances on the next cycle.
    - On acceptance of byte COUNT-1: tx_valid drops next cycle, last <= grant_id, rcnt cleared, go to IDLE.
    - tx_data is stable while tx_valid=1 and tx_ready=0.
- Byte order: most significant byte first, i.e. buf[0] = word[P_WIDTH-1 -: S_WIDTH].
- Request sampling:
  - req is sampled only in IDLE.
  - A req deasserted after grant but before ack is still serviced with the registered word.
  - A req that drops while the scheduler is in IDLE is simply not seen.
- Latency, with tx_ready held at 1: req seen at edge k, p2s_load high during cycle k+1, first tx_valid within COUNT+3 cycles of the load.
- Minimum turnaround between words is 1 IDLE cycle; this is by design.
- Fairness: the granted requester becomes lowest priority. With all req high, grants go 0,1,2,...,NREQ-1,0,...

Decomposition:
- Shared package p2s_pkg holds:
  - COUNT derivation and the width check;
  - state encoding (IDLE=0, LOAD=1, CAPTURE=2, DRAIN=3);
  - a clog2-based index width helper.
- One natural sub-module: rr_arbiter (NREQ requests, last pointer in, one-hot grant plus index out, purely combinational).
- The serializer stays a sibling instance wired at the parent level, not instantiated here.

Test Plan:
- Single word: req=4'b0001, word0=0xA1B2C3, tx_ready=1 -> one ack[0] pulse and one p2s_load pulse with p2s_data=0xA1B2C3. tx_data then shows A1, B2, C3, one byte per handshake, then idle=1.
- Contention: req=4'b1011 held, each bit dropped after its ack -> grant order 0,1,3. Exactly one ack per requester; bytes never interleave between words.
- Backpressure: tx_ready pattern 0,0,1,0,1,1 during DRAIN -> tx_data holds A1 through the stall cycles; exactly 3 transfers occur; no byte is lost or duplicated.
- Serializer busy: hold p2s_busy=1 for 5 cycles on LOAD entry -> no p2s_load and no ack for those cycles; load and ack happen on the first cycle busy=0.
- Reset mid-DRAIN: assert rst after byte B2 is accepted -> next cycle tx_valid=0, idle=1, grant_id=0. The next request from requester 2 is serviced first, with all 3 bytes.
- Round-robin wrap: req=4'b1111 continuously for 5 words -> grants 0,1,2,3,0.
